// File: rtl/simd_addsub_sequencer_if.sv
// rtl/simd_addsub_sequencer_if.sv - issue/result and shared-adder signal bundle for the SIMD add/sub sequencer
interface simd_addsub_sequencer_if #(
  parameter int LANES = 4
);
  // issue side
  logic                  start;
  logic [1:0]            op;
  logic [32*LANES-1:0]   va;
  logic [32*LANES-1:0]   vb;
  // result side
  logic                  busy;
  logic                  done;
  logic [32*LANES-1:0]   vs;
  logic [LANES-1:0]      ovf_mask;
  logic [LANES-1:0]      neg_mask;
  // shared adder side
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic                  add_sub;
  logic [31:0]           add_s;
  logic                  add_ovf;
  logic                  add_neg;

  // issue logic plus the shared adder (environment of the sequencer)
  modport master (
    output start, op, va, vb, add_s, add_ovf, add_neg,
    input  busy, done, vs, ovf_mask, neg_mask, add_a, add_b, add_sub
  );

  // the sequencer itself
  modport slave (
    input  start, op, va, vb, add_s, add_ovf, add_neg,
    output busy, done, vs, ovf_mask, neg_mask, add_a, add_b, add_sub
  );
endinterface

// File: rtl/simd_addsub_sequencer.sv
// rtl/simd_addsub_sequencer.sv - steps a LANES-wide add/sub/reduce through one shared 32-bit adder, one lane per clock
module simd_addsub_sequencer #(
  parameter int LANES = 4,
  parameter int CNT_W = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  simd_addsub_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_RED = 2'b10;

  // last counter value for lane ops and for reduce steps (reduce has LANES-1 steps)
  localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'((LANES > 1) ? (LANES - 2) : 0);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic [32*LANES-1:0]   r_va;
  logic [32*LANES-1:0]   r_vb;
  logic [32*LANES-1:0]   r_vs;
  logic [LANES-1:0]      r_ovf;
  logic [LANES-1:0]      r_neg;
  // during reduce r_add_a doubles as the running accumulator
  logic [31:0]           r_add_a;
  logic [31:0]           r_add_b;
  logic                  r_add_sub;
  logic                  r_busy;
  logic                  r_done;

  // lane select by counter value; out-of-range index yields zero
  function automatic logic [31:0] lane_of(input logic [32*LANES-1:0] v, input logic [CNT_W-1:0] idx);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == CNT_W'(i)) r = v[32*i +: 32];
    end
    return r;
  endfunction

  // sequencer FSM: accept, per-lane/per-step adder drive and result capture, one-cycle DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_ADD;
      r_va      <= '0;
      r_vb      <= '0;
      r_vs      <= '0;
      r_ovf     <= '0;
      r_neg     <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_sub <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_va  <= bus.va;
            r_vb  <= bus.vb;
            r_op  <= (bus.op == 2'b11) ? OP_ADD : bus.op;
            r_cnt <= '0;
            r_vs  <= '0;
            r_ovf <= '0;
            r_neg <= '0;
            if (bus.op == OP_RED && LANES == 1) begin
              // single-lane reduce needs no adder pass
              r_vs[31:0] <= bus.va[31:0];
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_add_a    <= '0;
              r_add_b    <= '0;
              r_add_sub  <= 1'b0;
            end else if (bus.op == OP_RED) begin
              // accumulator preloaded with lane0, first addend is lane1
              r_add_a   <= lane_of(bus.va, CNT_W'(0));
              r_add_b   <= lane_of(bus.va, CNT_W'(1));
              r_add_sub <= 1'b0;
              r_state   <= S_RUN;
              r_busy    <= 1'b1;
            end else begin
              r_add_a   <= lane_of(bus.va, CNT_W'(0));
              r_add_b   <= lane_of(bus.vb, CNT_W'(0));
              r_add_sub <= (bus.op == OP_SUB);
              r_state   <= S_RUN;
              r_busy    <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_RUN: begin
          if (r_op == OP_RED) begin
            r_ovf[0] <= r_ovf[0] | bus.add_ovf;
            r_neg[0] <= bus.add_neg;
            if (r_cnt == RED_LAST) begin
              r_vs[31:0] <= bus.add_s;
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_add_a    <= '0;
              r_add_b    <= '0;
              r_add_sub  <= 1'b0;
            end else begin
              r_add_a <= bus.add_s;
              r_add_b <= lane_of(r_va, r_cnt + CNT_W'(2));
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end else begin
            for (int i = 0; i < LANES; i++) begin
              if (r_cnt == CNT_W'(i)) begin
                r_vs[32*i +: 32] <= bus.add_s;
                r_ovf[i]         <= bus.add_ovf;
                r_neg[i]         <= bus.add_neg;
              end
            end
            if (r_cnt == LANE_LAST) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_add_a   <= '0;
              r_add_b   <= '0;
              r_add_sub <= 1'b0;
            end else begin
              r_add_a <= lane_of(r_va, r_cnt + CNT_W'(1));
              r_add_b <= lane_of(r_vb, r_cnt + CNT_W'(1));
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.vs       = r_vs;
  assign bus.ovf_mask = r_ovf;
  assign bus.neg_mask = r_neg;
  assign bus.add_a    = r_add_a;
  assign bus.add_b    = r_add_b;
  assign bus.add_sub  = r_add_sub;

endmodule

// File: tb/tb_simd_addsub_sequencer.sv
// tb/tb_simd_addsub_sequencer.sv - directed vector bench for simd_addsub_sequencer with a behavioural shared adder
module tb_simd_addsub_sequencer;

  localparam int LANES = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  simd_addsub_sequencer_if #(.LANES(LANES)) bus ();

  simd_addsub_sequencer #(.LANES(LANES), .CNT_W(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // shared 32-bit adder in the execute stage
  assign bus.add_s   = bus.add_sub ? (bus.add_a - bus.add_b) : (bus.add_a + bus.add_b);
  assign bus.add_ovf = bus.add_sub ?
                       ((bus.add_a[31] != bus.add_b[31]) && (bus.add_s[31] != bus.add_a[31])) :
                       ((bus.add_a[31] == bus.add_b[31]) && (bus.add_s[31] != bus.add_a[31]));
  assign bus.add_neg = bus.add_ovf ^ bus.add_s[31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [127:0] va;
    logic [127:0] vb;
    logic [127:0] exp_vs;
    logic [3:0]   exp_ovf;
    logic [3:0]   exp_neg;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.op    = v.op;
    bus.va    = v.va;
    bus.vb    = v.vb;
    bus.start = 1'b1;
  endtask

  // c0 is the cycle index (relative to the accept cycle) at the current negedge
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (bus.done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_result(input vec_t v);
    chk({v.name, " vs"},  bus.vs,       v.exp_vs);
    chk({v.name, " ovf"}, bus.ovf_mask, v.exp_ovf);
    chk({v.name, " neg"}, bus.neg_mask, v.exp_neg);
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    @(negedge clk);
    drive(v);
    @(negedge clk);
    bus.start = 1'b0;
    chk({v.name, " busy c1"}, bus.busy, 1'b1);
    chk({v.name, " add_a c1"}, bus.add_a, v.va[31:0]);
    chk({v.name, " add_b c1"}, bus.add_b, (v.op == 2'b10) ? v.va[63:32] : v.vb[31:0]);
    chk({v.name, " add_sub c1"}, bus.add_sub, (v.op == 2'b01));
    wait_done(1, c);
    chk({v.name, " latency"}, c, v.lat);
    check_result(v);
    chk({v.name, " add_a idle"}, bus.add_a, 32'd0);
    @(negedge clk);
    chk({v.name, " done pulse"}, bus.done, 1'b0);
    chk({v.name, " busy after"}, bus.busy, 1'b0);
    chk({v.name, " vs hold"}, bus.vs, v.exp_vs);
  endtask

  initial begin
    int   c;
    logic saw_done;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.va    = '0;
    bus.vb    = '0;

    vecs[0] = '{"add_ovf", 2'b00,
                {32'd4, 32'd3, 32'h7FFFFFFF, 32'd1}, {32'd1, 32'd1, 32'd1, 32'd1},
                {32'd5, 32'd4, 32'h80000000, 32'd2}, 4'b0010, 4'b0000, 5};
    vecs[1] = '{"sub_basic", 2'b01,
                {32'd0, 32'd0, 32'h80000000, 32'd5}, {32'd0, 32'd0, 32'd1, 32'd7},
                {32'd0, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFE}, 4'b0010, 4'b0011, 5};
    vecs[2] = '{"red_basic", 2'b10,
                {32'd4, 32'd3, 32'd2, 32'd1}, {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF},
                {32'd0, 32'd0, 32'd0, 32'd10}, 4'b0000, 4'b0000, 4};
    vecs[3] = '{"red_sticky", 2'b10,
                {32'hFFFFFFFF, 32'd0, 32'd1, 32'h7FFFFFFF}, 128'd0,
                {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF}, 4'b0001, 4'b0001, 4};
    vecs[4] = '{"op11_add", 2'b11,
                {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1},
                {32'd44, 32'd33, 32'd22, 32'd11}, 4'b0000, 4'b0000, 5};
    vecs[5] = '{"sub_wrap", 2'b01,
                {32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF},
                {32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF},
                {32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h80000000}, 4'b1001, 4'b1010, 5};
    vecs[6] = '{"add_wrap", 2'b00,
                {32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF},
                {32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd1},
                {32'hFFFFFFFE, 32'd0, 32'd0, 32'd0}, 4'b0100, 4'b1100, 5};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst vs", bus.vs, 128'd0);
    chk("rst ovf", bus.ovf_mask, 4'd0);
    chk("rst neg", bus.neg_mask, 4'd0);
    chk("rst add_a", bus.add_a, 32'd0);
    chk("rst add_b", bus.add_b, 32'd0);
    chk("rst add_sub", bus.add_sub, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // START mid-RUN ignored, then START held in DONE is accepted back-to-back
    @(negedge clk);
    drive(vecs[0]);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.op    = 2'b10;
    bus.va    = vecs[4].va;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, c);
    chk("b2b first latency", c, 5);
    check_result(vecs[0]);
    drive(vecs[1]);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b done low", bus.done, 1'b0);
    chk("b2b busy", bus.busy, 1'b1);
    chk("b2b vs clear", bus.vs, 128'd0);
    chk("b2b ovf clear", bus.ovf_mask, 4'd0);
    chk("b2b neg clear", bus.neg_mask, 4'd0);
    wait_done(1, c);
    chk("b2b second latency", c, 5);
    check_result(vecs[1]);

    // asynchronous reset in RUN cycle 2
    @(negedge clk);
    drive(vecs[0]);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", bus.busy, 1'b0);
    chk("arst done", bus.done, 1'b0);
    chk("arst vs", bus.vs, 128'd0);
    chk("arst ovf", bus.ovf_mask, 4'd0);
    chk("arst add_a", bus.add_a, 32'd0);
    chk("arst add_b", bus.add_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("arst no done", saw_done, 1'b0);
    run_vec(vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
